// File: rtl/da_fir_engine.sv
`default_nettype none
// ============================================================================
// Module   : da_fir_engine
// Brief    : Bit-serial distributed-arithmetic FIR. Each accepted sample is
//            processed MSB first over DATA_W cycles. The coefficient
//            partial-sum LUT is fixed at elaboration.
//            Optional macro DA_FIR_SAT_EN saturates DOUT instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module da_fir_engine #(
  parameter int          DATA_W = 8,
  parameter int          TAPS   = 4,
  parameter int          COEF_W = 8,
  parameter int unsigned C0     = 2,
  parameter int unsigned C1     = 4,
  parameter int unsigned C2     = 4,
  parameter int unsigned C3     = 2,
  parameter int          OUT_W  = 18
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic [OUT_W-1:0]  DOUT,
  output logic              DOUT_VALID,
  output logic              BUSY
);

  localparam int c_lut_w = COEF_W + 2;
  localparam int c_lut_n = 1 << TAPS;
  localparam int c_acc_w = DATA_W + COEF_W + 2;
  localparam int c_cnt_w = $clog2(DATA_W);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_accum = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [DATA_W-1:0]  r_x [TAPS];
  logic [c_acc_w-1:0] r_acc;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic [OUT_W-1:0]   r_dout;
  logic               r_dout_valid;

  logic [c_lut_w-1:0] w_lut [c_lut_n];
  logic [TAPS-1:0]    w_addr;
  logic [c_cnt_w-1:0] w_bit_sel;
  logic               w_last_bit;
  logic [OUT_W-1:0]   w_dout_nxt;

  // Entry a holds the sum of every coefficient whose tap bit is set in a.
  function automatic logic [c_lut_w-1:0] lut_entry(input int unsigned a);
    int unsigned s;
    s = 0;
    if (a[0]) s += C0;
    if (a[1]) s += C1;
    if (TAPS > 2 && a[2]) s += C2;
    if (TAPS > 3 && a[3]) s += C3;
    return s[c_lut_w-1:0];
  endfunction

  for (genvar a = 0; a < c_lut_n; a++) begin : g_lut
    assign w_lut[a] = lut_entry(a);
  end

  assign w_bit_sel  = c_cnt_w'(DATA_W - 1) - r_bit_cnt;
  assign w_last_bit = (r_bit_cnt == c_cnt_w'(DATA_W - 1));

  for (genvar k = 0; k < TAPS; k++) begin : g_addr
    assign w_addr[k] = r_x[k][w_bit_sel];
  end

`ifdef DA_FIR_SAT_EN
  localparam int c_ext_w = (OUT_W > c_acc_w) ? OUT_W : c_acc_w;
  logic [c_ext_w-1:0] w_acc_ext;
  logic               w_over;
  assign w_acc_ext  = c_ext_w'(r_acc);
  assign w_over     = (w_acc_ext >> OUT_W) != '0;
  assign w_dout_nxt = w_over ? '1 : w_acc_ext[OUT_W-1:0];
`else
  assign w_dout_nxt = OUT_W'(r_acc);
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= c_st_idle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (DIN_VALID) w_state_nxt = c_st_accum;
      c_st_accum: if (w_last_bit) w_state_nxt = c_st_done;
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    DIN_READY = (r_state == c_st_idle);
    BUSY      = (r_state == c_st_accum) || (r_state == c_st_done);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < TAPS; k++) r_x[k] <= '0;
      r_acc        <= '0;
      r_bit_cnt    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= (r_state == c_st_done);
      case (r_state)
        c_st_idle: begin
          if (DIN_VALID) begin
            r_x[0] <= DIN;
            for (int k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
            r_acc     <= '0;
            r_bit_cnt <= '0;
          end
        end
        c_st_accum: begin
          r_acc     <= (r_acc << 1) + c_acc_w'(w_lut[w_addr]);
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        c_st_done: r_dout <= w_dout_nxt;
        default: ;
      endcase
    end
  end

  assign DOUT       = r_dout;
  assign DOUT_VALID = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_da_fir_engine.sv
`default_nettype none
// Testbench for da_fir_engine: three instances (defaults, OUT_W=11, and a
// 2-tap 4-bit build) checked by a scoreboard against an arithmetic FIR model.
module tb_da_fir_engine;

`ifdef DA_FIR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int DWA = 8;
  localparam int DWB = 4;

  typedef struct {
    longint val;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b1;
  logic rst_b = 1'b1;

  logic [7:0]  din_a = '0;
  logic        vld_a = 1'b0;
  logic        rdy_a, busy_a, dv_a, rdy_w, busy_w, dv_w;
  logic [17:0] dout_a;
  logic [10:0] dout_w;

  logic [3:0]  din_b = '0;
  logic        vld_b = 1'b0;
  logic        rdy_b, busy_b, dv_b;
  logic [6:0]  dout_b;

  da_fir_engine u_dut_a (
    .CLK(clk), .RESET(rst), .DIN(din_a), .DIN_VALID(vld_a), .DIN_READY(rdy_a),
    .DOUT(dout_a), .DOUT_VALID(dv_a), .BUSY(busy_a)
  );

  da_fir_engine #(.OUT_W(11)) u_dut_w (
    .CLK(clk), .RESET(rst), .DIN(din_a), .DIN_VALID(vld_a), .DIN_READY(rdy_w),
    .DOUT(dout_w), .DOUT_VALID(dv_w), .BUSY(busy_w)
  );

  da_fir_engine #(.DATA_W(4), .TAPS(2), .COEF_W(4), .C0(3), .C1(5), .OUT_W(7)) u_dut_b (
    .CLK(clk), .RESET(rst_b), .DIN(din_b), .DIN_VALID(vld_b), .DIN_READY(rdy_b),
    .DOUT(dout_b), .DOUT_VALID(dv_b), .BUSY(busy_b)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_a = -100;
  int acc_b = -100;
  int unsigned ha [4];
  int unsigned hb [2];
  exp_t qa[$], qw[$], qb[$];
  longint last_a = 0, last_w = 0, last_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic longint fit(input longint v, input int w);
    longint lim;
    lim = longint'(1) << w;
    if (SAT && v >= lim) return lim - 1;
    return v % lim;
  endfunction

  // Default-parameter instances: sum of Ck*x[k] with C = {2,4,4,2}.
  always @(negedge clk) begin
    bit   busy_exp;
    longint s;
    exp_t e;
    if (rst) begin
      qa.delete(); qw.delete();
      for (int k = 0; k < 4; k++) ha[k] = 0;
      acc_a = -100; last_a = 0; last_w = 0;
    end else begin
      busy_exp = (cyc >= acc_a) && (cyc <= acc_a + DWA);
      chk("busy_a", busy_a, busy_exp);
      chk("ready_a", rdy_a, !busy_exp);
      chk("busy_w", busy_w, busy_exp);
      chk("ready_w", rdy_w, !busy_exp);
      if (vld_a && !busy_exp) begin
        for (int k = 3; k > 0; k--) ha[k] = ha[k-1];
        ha[0] = din_a;
        s = 2 * ha[0] + 4 * ha[1] + 4 * ha[2] + 2 * ha[3];
        e.due = cyc + DWA + 2;
        e.val = fit(s, 18); qa.push_back(e);
        e.val = fit(s, 11); qw.push_back(e);
        acc_a = cyc + 1;
      end
      if (dv_a) begin
        if (qa.size() == 0) flag("dout_valid_a unexpected");
        else begin
          e = qa.pop_front();
          chk("dout_a", dout_a, e.val);
          chk("latency_a", cyc, e.due);
          last_a = e.val;
        end
      end else begin
        chk("hold_a", dout_a, last_a);
        if (qa.size() > 0 && cyc > qa[0].due) begin
          flag("dout_valid_a missing");
          void'(qa.pop_front());
        end
      end
      if (dv_w) begin
        if (qw.size() == 0) flag("dout_valid_w unexpected");
        else begin
          e = qw.pop_front();
          chk("dout_w", dout_w, e.val);
          chk("latency_w", cyc, e.due);
          last_w = e.val;
        end
      end else begin
        chk("hold_w", dout_w, last_w);
        if (qw.size() > 0 && cyc > qw[0].due) begin
          flag("dout_valid_w missing");
          void'(qw.pop_front());
        end
      end
    end
  end

  // Two-tap 4-bit instance: 3*x[0] + 5*x[1].
  always @(negedge clk) begin
    bit   busy_exp;
    exp_t e;
    if (rst_b) begin
      qb.delete(); hb[0] = 0; hb[1] = 0; acc_b = -100; last_b = 0;
    end else begin
      busy_exp = (cyc >= acc_b) && (cyc <= acc_b + DWB);
      chk("busy_b", busy_b, busy_exp);
      chk("ready_b", rdy_b, !busy_exp);
      if (vld_b && !busy_exp) begin
        hb[1] = hb[0];
        hb[0] = din_b;
        e.val = fit(3 * hb[0] + 5 * hb[1], 7);
        e.due = cyc + DWB + 2;
        qb.push_back(e);
        acc_b = cyc + 1;
      end
      if (dv_b) begin
        if (qb.size() == 0) flag("dout_valid_b unexpected");
        else begin
          e = qb.pop_front();
          chk("dout_b", dout_b, e.val);
          chk("latency_b", cyc, e.due);
          last_b = e.val;
        end
      end else begin
        chk("hold_b", dout_b, last_b);
        if (qb.size() > 0 && cyc > qb[0].due) begin
          flag("dout_valid_b missing");
          void'(qb.pop_front());
        end
      end
    end
  end

  task automatic send_a(input logic [7:0] v, input bit keep);
    int n;
    n = 0;
    din_a = v;
    vld_a = 1'b1;
    @(negedge clk);
    while (!rdy_a && n < 50) begin n++; @(negedge clk); end
    if (!rdy_a) flag("timeout waiting for ready_a");
    @(posedge clk); #1;
    if (!keep) vld_a = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] v);
    int n;
    n = 0;
    din_b = v;
    vld_b = 1'b1;
    @(negedge clk);
    while (!rdy_b && n < 50) begin n++; @(negedge clk); end
    if (!rdy_b) flag("timeout waiting for ready_b");
    @(posedge clk); #1;
    vld_b = 1'b0;
  endtask

  // Offer junk while busy, withdrawing it before the engine becomes ready.
  task automatic junk_a(input int n);
    for (int i = 0; i < n; i++) begin
      if (rdy_a) break;
      din_a = 8'($urandom);
      vld_a = 1'b1;
      @(posedge clk); #1;
    end
    vld_a = 1'b0;
  endtask

  task automatic drive_a();
    logic [7:0] v;
    send_a(8'd1, 1'b1); send_a(8'd0, 1'b1); send_a(8'd0, 1'b1); send_a(8'd0, 1'b0);
    repeat (4) send_a(8'd255, 1'b0);
    send_a(8'd255, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset dout_a", dout_a, 0);
    chk("reset dout_valid_a", dv_a, 0);
    chk("reset ready_a", rdy_a, 1);
    chk("reset busy_a", busy_a, 0);
    chk("reset dout_w", dout_w, 0);
    @(posedge clk); #1 rst = 1'b0;
    send_a(8'd1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      v = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
      send_a(v, 1'b0);
      if ($urandom_range(0, 2) == 0) junk_a($urandom_range(1, 12));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drive_b();
    send_b(4'd15); send_b(4'd15);
    for (int i = 0; i < 20; i++) begin
      send_b(4'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset dout_a", dout_a, 0);
    chk("reset dout_valid_a", dv_a, 0);
    chk("reset ready_a", rdy_a, 1);
    chk("reset busy_a", busy_a, 0);
    chk("reset dout_w", dout_w, 0);
    chk("reset dout_b", dout_b, 0);
    chk("reset ready_b", rdy_b, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    rst_b = 1'b0;
    fork
      drive_a();
      drive_b();
    join
    n = 0;
    while ((qa.size() != 0 || qw.size() != 0 || qb.size() != 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("pending results a", qa.size(), 0);
    chk("pending results w", qw.size(), 0);
    chk("pending results b", qb.size(), 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/da_fir_engine.md
Name: da_fir_engine

Overview:
- Parametrised, bit-serial distributed-arithmetic (DA) FIR engine for the fir sample.
- Replaces fixed per-coefficient multiply ROMs with one internal lookup table of coefficient partial sums, built at elaboration from parameters.
- Accepts unsigned samples through a valid/ready handshake, processes each over DATA_W cycles, and emits one filtered result per accepted sample.

Parameters:
- DATA_W, 8, input sample width (unsigned); legal range 2..16.
- TAPS, 4, number of filter taps; legal range 2..4.
- COEF_W, 8, coefficient width (unsigned).
- C0, 2, coefficient of the newest sample.
- C1, 4, coefficient of tap 1.
- C2, 4, coefficient of tap 2; ignored when TAPS<3.
- C3, 2, coefficient of tap 3; ignored when TAPS<4.
- OUT_W, 18, result width.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-high reset.
- DIN  in  DATA_W  input sample.
- DIN_VALID  in  1  DIN holds a sample.
- DIN_READY  out  1  engine can accept a sample; high only in IDLE.
- DOUT  out  OUT_W  filter result, registered.
- DOUT_VALID  out  1  one-cycle pulse; DOUT is new.
- BUSY  out  1  high in ACCUM or DONE.

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - state=IDLE
  - delay line x[0..TAPS-1]=0
  - accumulator=0, bit counter=0
  - DOUT=0, DOUT_VALID=0, BUSY=0
  - DIN_READY=1 (decoded from IDLE)
- LUT: 2^TAPS entries. Entry a = sum of Ck for every k with bit k of a set. Width COEF_W+2, unsigned. Constant; no run-time load.
- IDLE: on DIN_VALID && DIN_READY at an edge:
  - x[k]<=x[k-1] for k>=1, x[0]<=DIN
  - acc<=0, bit_cnt<=0
  - go to ACCUM.
  - Otherwise hold all state.
- ACCUM: each cycle:
  - addr bit k = x[k][DATA_W-1-bit_cnt] (MSB first)
  - acc<=(acc<<1)+LUT[addr], bit_cnt<=bit_cnt+1
  - after the cycle with bit_cnt=DATA_W-1, go to DONE.
  - DIN is ignored and DIN_READY=0.
- DONE (one cycle):
  - DOUT<=acc[OUT_W-1:0] (modulo 2^OUT_W; no saturation unless the optional feature is enabled)
  - DOUT_VALID<=1 for exactly one cycle
  - go to IDLE.
- Internal accumulator width: DATA_W+COEF_W+2, so no internal overflow occurs.
- Result equals sum over k of Ck*x[k].
- Latency: sample accepted at edge T gives DOUT_VALID high after edge T+DATA_W+1.
- Throughput: one sample per DATA_W+2 cycles.
- DOUT holds its value until the next DONE.
- DIN_VALID held high while busy: the sample is not consumed. It is accepted on the first IDLE edge with DIN_READY=1.
- DIN_VALID deasserted before acceptance: nothing is consumed; no error.
- RESET asserted mid-ACCUM or in DONE: immediate return to reset values. The partial result is discarded, no DOUT_VALID is issued, and the delay line is cleared.
- A DONE cycle followed by a new sample: DOUT_VALID and acceptance happen on different cycles. Acceptance occurs in IDLE, the cycle after DONE.

Optional Feature:
- Macro DA_FIR_SAT_EN.
- Defined: in DONE, if acc >= 2^OUT_W then DOUT<=all ones, else DOUT<=acc.
- Undefined: DOUT<=acc modulo 2^OUT_W (wrap).
- With OUT_W >= DATA_W+COEF_W+clog2(TAPS), both modes give identical results.

Test Plan:
- Impulse, defaults: samples 1,0,0,0 each accepted when ready -> DOUT sequence 2,4,4,2, each with a single DOUT_VALID pulse 9 edges after acceptance.
- Step, defaults: samples 255,255,255,255 -> DOUT 510,1530,2550,3060.
- Handshake: DIN_VALID held high with DIN=1 from reset, then DIN=0 -> acceptances exactly 10 cycles apart; DIN_READY=0 and BUSY=1 for 9 cycles after each acceptance; no sample lost or duplicated; outputs 2,4,4,2.
- Reset mid-operation: accept 255, assert RESET at ACCUM cycle 4 -> DOUT=0, DOUT_VALID never pulses, DIN_READY=1; then impulse 1 -> DOUT=2.
- Wrap vs saturate, OUT_W=11, step 255 x4:
  - without DA_FIR_SAT_EN -> 510,1530,502,1012
  - with DA_FIR_SAT_EN -> 510,1530,2047,2047.
- Parameter sweep: TAPS=2, DATA_W=4, C0=3, C1=5, samples 15,15 -> DOUT 45,120, latency 5 edges.
